seq_divider: RTL and testbench

Iterative unsigned restoring divider. It is the inverse companion to the team's pipelined 8x8 array multiplier: it recovers an 8-bit factor and remainder from a 16-bit product-width value. It resolves one quotient bit per clock under a start/ready/done handshake. It sits beside the multiplier in the arithmetic datapath and is used for scaling and normalisation.

---
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional early-out for dividend < divisor is enabled by defining SEQ_DIVIDER_EARLY_OUT_EN.
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned TW = DW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   rem_q, rem_n;
  logic [DW-1:0]   low_q, low_n;
  logic [DW-1:0]   dsr_q, dsr_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [DW-1:0]   quo_n, remo_n;
  logic            dbz_n, ovf_n;

  logic [TW-1:0]   trial;
  logic            qbit;
  logic [DW-1:0]   rem_step;
  logic [DW-1:0]   low_step;

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  always_comb begin
    trial    = {rem_q, low_q[DW-1]};
    qbit     = (trial >= {1'b0, dsr_q});
    rem_step = qbit ? DW'(trial - {1'b0, dsr_q}) : trial[DW-1:0];
    low_step = {low_q[DW-2:0], qbit};
  end

  // Next-state and datapath next values.
  always_comb begin
    state_n = state;
    rem_n   = rem_q;
    low_n   = low_q;
    dsr_n   = dsr_q;
    cnt_n   = cnt_q;
    quo_n   = quotient;
    remo_n  = remainder;
    dbz_n   = div_by_zero;
    ovf_n   = overflow;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          dsr_n = divisor;
          if (divisor == '0) begin
            dbz_n   = 1'b1;
            ovf_n   = 1'b0;
            quo_n   = 8'hFF;
            remo_n  = 8'h00;
            state_n = S_DONE;
          end else if (dividend[15:8] >= divisor) begin
            dbz_n   = 1'b0;
            ovf_n   = 1'b1;
            quo_n   = 8'hFF;
            remo_n  = 8'h00;
            state_n = S_DONE;
          end else begin
            dbz_n = 1'b0;
            ovf_n = 1'b0;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
            if (dividend < {8'h00, divisor}) begin
              quo_n   = 8'h00;
              remo_n  = dividend[7:0];
              state_n = S_DONE;
            end else begin
              rem_n   = dividend[15:8];
              low_n   = dividend[7:0];
              cnt_n   = '0;
              state_n = S_CALC;
            end
`else
            rem_n   = dividend[15:8];
            low_n   = dividend[7:0];
            cnt_n   = '0;
            state_n = S_CALC;
`endif
          end
        end
      end
      S_CALC: begin
        rem_n = rem_step;
        low_n = low_step;
        cnt_n = cnt_q + CW'(1);
        if (cnt_q == CW'(7)) begin
          quo_n   = low_step;
          remo_n  = rem_step;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rem_q       <= '0;
      low_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      rem_q       <= rem_n;
      low_q       <= low_n;
      dsr_q       <= dsr_n;
      cnt_q       <= cnt_n;
      quotient    <= quo_n;
      remainder   <= remo_n;
      div_by_zero <= dbz_n;
      overflow    <= ovf_n;
      ready       <= (state_n == S_IDLE);
      busy        <= (state_n == S_CALC);
      done        <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random-sweep bench for seq_divider.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready, busy, done;
  logic [7:0]  quotient, remainder;
  logic        div_by_zero, overflow;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  seq_divider dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Present operands at a falling edge once ready; returns #1 after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    wait_ready();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 50) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int elat,
                              input logic [7:0] eq, input logic [7:0] er,
                              input logic edz, input logic eov);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    check({tag, "_ov"}, 32'(overflow), 32'(eov));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eov, input int elat);
    int lat, nb;
    issue(a, b);
    wait_done(lat, nb);
    check_result(tag, lat, elat, eq, er, edz, eov);
    check({tag, "_rdy"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int lat, nb, bad;
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  hi;
    int eq, er, elat;

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);

    // Normal divide with busy-length check.
    issue(16'd1000, 8'd7);
    wait_done(lat, nb);
    check_result("n1000_7", lat, 9, 8'd142, 8'd6, 1'b0, 1'b0);
    check("n1000_7_busy", 32'(nb), 32'd8);

    run_op("maxq", 16'hFEFF, 8'hFF, 8'd255, 8'd254, 1'b0, 1'b0, 9);
    run_op("ovf", 16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    run_op("dbz", 16'd100, 8'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
    run_op("dbz_prio", 16'hFFFF, 8'd0, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
    run_op("ovf_eq", 16'h0700, 8'd7, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    run_op("early", 16'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0, EARLY ? 1 : 9);

    // Start held high during CALC is ignored; the pending request is taken once ready.
    issue(16'd1000, 8'd7);
    dividend = 16'd50; divisor = 8'd5; start = 1'b1;
    wait_done(lat, nb);
    check_result("busy_ign", lat, 9, 8'd142, 8'd6, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("busy_ign_rdy", 32'(ready), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    check("second_busy", 32'(busy), 32'd1);
    wait_done(lat, nb);
    check_result("second", lat, 9, 8'd10, 8'd0, 1'b0, 1'b0);

    // Reset during step 4 aborts with no done pulse.
    issue(16'd1000, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    bad = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done) bad++;
    end
    check("abort_nodone", 32'(bad), 32'd0);
    run_op("post_rst", 16'd200, 8'd9, 8'd22, 8'd2, 1'b0, 1'b0, 9);

    // Random non-error sweep against integer division.
    for (int i = 0; i < 2000; i++) begin
      b  = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, 32'(b) - 1));
      a  = {hi, 8'($urandom_range(0, 255))};
      eq = 32'(a) / 32'(b);
      er = 32'(a) % 32'(b);
      elat = (EARLY && (a < {8'h00, b})) ? 1 : 9;
      issue(a, b);
      wait_done(lat, nb);
      if (done !== 1'b1 || lat != elat || quotient != 8'(eq) || remainder != 8'(er) ||
          div_by_zero || overflow) begin
        $display("FAIL rnd a=%0d b=%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=%0d",
                 a, b, quotient, remainder, lat, eq, er, elat);
        errors++;
      end
      checks++;
      check("rnd_inv", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check("rnd_rlt", 32'(remainder < b), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
